// File: rtl/vec_divider_pkg.sv
// Shared vALU definitions for the SIMD divider: element-width and op codes,
// FSM states and lane-partitioning helpers over a 64-bit beat.
package vec_divider_pkg;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        OP_DIVU = 2'b00,
        OP_DIV  = 2'b01,
        OP_REMU = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ITER  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // One bit set at the most significant bit of every lane.
    function automatic logic [63:0] lane_msb_mask(input logic [1:0] sew);
        logic [63:0] m;
        m = 64'h8000_0000_0000_0000;
        case (sew)
            SEW_8:   m = 64'h8080_8080_8080_8080;
            SEW_16:  m = 64'h8000_8000_8000_8000;
            SEW_32:  m = 64'h8000_0000_8000_0000;
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic [6:0] iter_count(input logic [1:0] sew, input logic en64);
        logic [6:0] w;
        w = 7'd0;
        case (sew)
            SEW_8:   w = 7'd8;
            SEW_16:  w = 7'd16;
            SEW_32:  w = 7'd32;
            default: w = en64 ? 7'd64 : 7'd0;
        endcase
        return w;
    endfunction

    // Copy the bit found at each lane MSB across the whole lane.
    function automatic logic [63:0] lane_bcast(input logic [63:0] v, input logic [1:0] sew);
        logic [63:0] m;
        logic [63:0] r;
        logic        k;
        m = lane_msb_mask(sew);
        r = '0;
        k = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (m[i]) k = v[i];
            r[i] = k;
        end
        return r;
    endfunction

    // OR-reduction of each lane, reported at the lane MSB position only.
    function automatic logic [63:0] lane_any(input logic [63:0] x, input logic [1:0] sew);
        logic [63:0] m;
        logic [63:0] l;
        logic [63:0] r;
        logic        acc;
        m   = lane_msb_mask(sew);
        l   = {m[62:0], 1'b1};
        r   = '0;
        acc = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (l[i]) acc = 1'b0;
            acc = acc | x[i];
            if (m[i]) r[i] = acc;
        end
        return r;
    endfunction

    // Two's-complement negate per lane; the carry never crosses a lane boundary.
    function automatic logic [63:0] lane_neg(input logic [63:0] x, input logic [1:0] sew);
        logic [63:0] l;
        logic [63:0] r;
        logic        c;
        l = {lane_msb_mask(sew)[62:0], 1'b1};
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (l[i]) c = 1'b1;
            r[i] = ~x[i] ^ c;
            c    = ~x[i] & c;
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_divider_step.sv
// One restoring-division step applied to every lane of a partitioned 64-bit
// {remainder, quotient} pair; purely combinational.
module vec_div_step
    import vec_divider_pkg::*;
(
    input  logic [63:0] rem_i,
    input  logic [63:0] quot_i,
    input  logic [63:0] div_i,
    input  logic [1:0]  sew_i,
    output logic [63:0] rem_o,
    output logic [63:0] quot_o
);

    logic [63:0] msb;
    logic [63:0] lsb;
    logic [63:0] q_sh;
    logic [63:0] r_shl;
    logic [63:0] r_sh;
    logic [63:0] diff;
    logic [63:0] keep_at;
    logic [63:0] keep;
    logic        q_top;
    logic        brw;
    logic        k;

    always_comb begin
        msb     = lane_msb_mask(sew_i);
        lsb     = {msb[62:0], 1'b1};
        q_sh    = {quot_i[62:0], 1'b0} & ~lsb;
        r_shl   = {rem_i[62:0], 1'b0};
        r_sh    = '0;
        diff    = '0;
        keep_at = '0;
        keep    = '0;
        q_top   = 1'b0;
        brw     = 1'b0;
        k       = 1'b0;

        // The quotient MSB of each lane feeds the LSB of that lane's remainder.
        for (int i = 63; i >= 0; i--) begin
            if (msb[i]) q_top = quot_i[i];
            r_sh[i] = lsb[i] ? q_top : r_shl[i];
        end

        // The rem bit shifted out of a lane is an implicit extra MSB: if set,
        // the trial subtraction always succeeds.
        for (int i = 0; i < 64; i++) begin
            if (lsb[i]) brw = 1'b0;
            diff[i] = r_sh[i] ^ div_i[i] ^ brw;
            brw     = (~r_sh[i] & div_i[i]) | (~(r_sh[i] ^ div_i[i]) & brw);
            if (msb[i]) keep_at[i] = rem_i[i] | ~brw;
        end

        for (int i = 63; i >= 0; i--) begin
            if (msb[i]) k = keep_at[i];
            keep[i] = k;
        end

        rem_o  = (diff & keep) | (r_sh & ~keep);
        quot_o = q_sh | (keep & lsb);
    end

endmodule

// File: rtl/vec_divider.sv
// Iterative SIMD divide/remainder unit: one 64-bit beat of packed lanes,
// radix-2 restoring division in all lanes in parallel, ready/valid input.
module vec_divider
    import vec_divider_pkg::*;
#(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int SEW_WIDTH       = 2,
    parameter int OPSEL_WIDTH     = 2,
    parameter int DIV64_ENABLE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_DATA_WIDTH-1:0]  in_vec0,
    input  logic [REQ_DATA_WIDTH-1:0]  in_vec1,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEW_WIDTH-1:0]       in_sew,
    input  logic [OPSEL_WIDTH-1:0]     in_opSel,
    output logic [RESP_DATA_WIDTH-1:0] out_vec,
    output logic                       out_valid,
    output logic [1:0]                 dbg_state_o
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // in_ready is high in IDLE and DONE only; out_valid is a one-cycle strobe in DONE.

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [1:0]  sew_q, sew_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] quot_q, quot_d;
    logic [63:0] div_q, div_d;
    logic [63:0] a_q, a_d;
    logic [63:0] sa_q, sa_d;
    logic [63:0] sb_q, sb_d;
    logic [63:0] dz_q, dz_d;
    logic [63:0] ov_q, ov_d;
    logic [63:0] out_q, out_d;

    logic        accept;
    logic        in_signed;
    logic [63:0] in_msb;
    logic [63:0] in_sa;
    logic [63:0] in_sb;
    logic [63:0] in_abs_a;
    logic [63:0] in_abs_b;
    logic [63:0] in_dz;
    logic [63:0] in_ov;
    logic [63:0] step_rem;
    logic [63:0] step_quot;
    logic [6:0]  w_cnt;
    logic [63:0] q_neg;
    logic [63:0] q_fix;
    logic [63:0] r_fix;
    logic [63:0] q_fin;
    logic [63:0] r_fin;
    logic [63:0] result;

    assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_vec     = out_q;
    assign dbg_state_o = state_q;
    assign accept      = in_valid && in_ready;

    // Operand conditioning on the request: signs, magnitudes, special lanes.
    always_comb begin
        in_msb    = lane_msb_mask(in_sew);
        in_signed = (in_opSel == OP_DIV) || (in_opSel == OP_REM);
        in_sa     = in_signed ? lane_bcast(in_vec0 & in_msb, in_sew) : '0;
        in_sb     = in_signed ? lane_bcast(in_vec1 & in_msb, in_sew) : '0;
        in_abs_a  = (lane_neg(in_vec0, in_sew) & in_sa) | (in_vec0 & ~in_sa);
        in_abs_b  = (lane_neg(in_vec1, in_sew) & in_sb) | (in_vec1 & ~in_sb);
        in_dz     = lane_bcast(~lane_any(in_vec1, in_sew) & in_msb, in_sew);
        in_ov     = in_signed
                  ? lane_bcast(~lane_any(in_vec0 ^ in_msb, in_sew)
                               & ~lane_any(~in_vec1, in_sew) & in_msb, in_sew)
                  : '0;
    end

    vec_div_step u_step (
        .rem_i  (rem_q),
        .quot_i (quot_q),
        .div_i  (div_q),
        .sew_i  (sew_q),
        .rem_o  (step_rem),
        .quot_o (step_quot)
    );

    // Sign restoration and special-lane overrides applied in FIXUP.
    always_comb begin
        w_cnt  = iter_count(sew_q, DIV64_ENABLE != 0);
        q_neg  = sa_q ^ sb_q;
        q_fix  = (lane_neg(quot_q, sew_q) & q_neg) | (quot_q & ~q_neg);
        r_fix  = (lane_neg(rem_q, sew_q) & sa_q) | (rem_q & ~sa_q);
        q_fin  = (q_fix & ~dz_q & ~ov_q) | dz_q | (a_q & ov_q);
        r_fin  = (r_fix & ~dz_q & ~ov_q) | (a_q & dz_q);
        result = ((op_q == OP_REMU) || (op_q == OP_REM)) ? r_fin : q_fin;
        if (w_cnt == 7'd0) result = '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sew_d   = sew_q;
        op_d    = op_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        div_d   = div_q;
        a_d     = a_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = ST_ITER;
                    cnt_d   = '0;
                    sew_d   = in_sew;
                    op_d    = in_opSel;
                    rem_d   = '0;
                    quot_d  = in_abs_a;
                    div_d   = in_abs_b;
                    a_d     = in_vec0;
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    dz_d    = in_dz;
                    ov_d    = in_ov;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // W step cycles then one settle cycle (cnt == W) keeps latency at W+2.
            ST_ITER: begin
                if (cnt_q == w_cnt) begin
                    state_d = ST_FIXUP;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q + 7'd1;
                end
            end
            ST_FIXUP: begin
                out_d   = result;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sew_q   <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
            a_q     <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            dz_q    <= '0;
            ov_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sew_q   <= sew_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            div_q   <= div_d;
            a_q     <= a_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_vec_divider.sv
// Directed bench for vec_divider: scoreboard queue filled at issue, monitor
// pops on every out_valid strobe; timing and reset windows checked inline.
module tb_vec_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_vec0 = '0;
    logic [63:0] in_vec1 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sew = '0;
    logic [1:0]  in_opSel = '0;
    logic [63:0] out_vec;
    logic        out_valid;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] mon_exp;
    string       mon_name;

    vec_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_vec0     (in_vec0),
        .in_vec1     (in_vec1),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sew      (in_sew),
        .in_opSel    (in_opSel),
        .out_vec     (out_vec),
        .out_valid   (out_valid),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request once in_ready is seen; expectation queued at issue.
    task automatic send(input logic [63:0] v0, input logic [63:0] v1, input logic [1:0] sew,
                        input logic [1:0] op, input logic [63:0] exp, input string name);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        in_vec0  = v0;
        in_vec1  = v1;
        in_sew   = sew;
        in_opSel = op;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out_valid: got strobe with out_vec=%h, expected no response", out_vec);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, out_vec, mon_exp);
            end
        end
    end

    initial begin
        int ready_bad;
        int valid_bad;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_vec", out_vec, 64'd0);

        // Directed vectors with hand-computed results.
        send(64'h0000_0000_0000_00C8, 64'h0101_0101_0101_0107, 2'b00, 2'b00, 64'h0000_0000_0000_001C, "sew8_divu");
        send(64'h0000_0000_0000_00C8, 64'h0101_0101_0101_0107, 2'b00, 2'b10, 64'h0000_0000_0000_0004, "sew8_remu");
        send(64'h0000_0000_0000_00F9, 64'h0101_0101_0101_0102, 2'b00, 2'b01, 64'h0000_0000_0000_00FD, "sew8_div_neg");
        send(64'h0000_0000_0000_00F9, 64'h0101_0101_0101_0102, 2'b00, 2'b11, 64'h0000_0000_0000_00FF, "sew8_rem_neg");
        send(64'h0000_0000_0000_00F9, 64'h0101_0101_0101_0100, 2'b00, 2'b01, 64'h0000_0000_0000_00FF, "sew8_div_by0");
        send(64'h0000_0000_0000_00F9, 64'h0101_0101_0101_0100, 2'b00, 2'b11, 64'h0000_0000_0000_00F9, "sew8_rem_by0");
        send(64'h0000_0000_0000_0005, 64'h0000_0001_0000_0000, 2'b10, 2'b00, 64'h0000_0000_FFFF_FFFF, "sew32_divu_by0");
        send(64'h0000_0000_0000_0005, 64'h0000_0001_0000_0000, 2'b10, 2'b10, 64'h0000_0000_0000_0005, "sew32_remu_by0");
        send(64'h0000_0000_0000_8000, 64'h0001_0001_0001_FFFF, 2'b01, 2'b01, 64'h0000_0000_0000_8000, "sew16_div_ovf");
        send(64'h0000_0000_0000_8000, 64'h0001_0001_0001_FFFF, 2'b01, 2'b11, 64'h0000_0000_0000_0000, "sew16_rem_ovf");
        send(64'hFFFF_03E8_0007_0064, 64'h00FF_000A_0009_0003, 2'b01, 2'b00, 64'h0101_0064_0000_0021, "sew16_divu_mix");
        send(64'hFFFF_03E8_0007_0064, 64'h00FF_000A_0009_0003, 2'b01, 2'b10, 64'h0000_0000_0007_0001, "sew16_remu_mix");
        send(64'h0000_0064_FFFF_FF9C, 64'hFFFF_FFF9_0000_0007, 2'b10, 2'b01, 64'hFFFF_FFF2_FFFF_FFF2, "sew32_div_signs");
        send(64'h0000_0064_FFFF_FF9C, 64'hFFFF_FFF9_0000_0007, 2'b10, 2'b11, 64'h0000_0002_FFFF_FFFE, "sew32_rem_signs");
        wait_drain("directed");

        // SEW=32 latency, in_valid held high, back-to-back second request.
        in_vec0  = 64'h0000_0064_0000_03E8;
        in_vec1  = 64'h0000_0007_0000_000A;
        in_sew   = 2'b10;
        in_opSel = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(64'h0000_000E_0000_0064);
        name_q.push_back("b2b_first");
        ready_bad = 0;
        valid_bad = 0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 1) begin
                in_vec0  = 64'h0000_0011_0000_0020;
                in_vec1  = 64'h0000_0005_0000_0006;
                in_opSel = 2'b10;
            end
            if (in_ready) ready_bad++;
            if (out_valid) valid_bad++;
        end
        check("b2b_ready_low_cycles", 64'(ready_bad), 64'd0);
        check("b2b_no_early_valid", 64'(valid_bad), 64'd0);
        @(negedge clk);
        check("b2b_valid_cycle35", 64'(out_valid), 64'd1);
        check("b2b_ready_cycle35", 64'(in_ready), 64'd1);
        exp_q.push_back(64'h0000_0002_0000_0002);
        name_q.push_back("b2b_second");
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_second_accepted", 64'(in_ready), 64'd0);
        wait_drain("b2b");
        check("out_vec_hold", out_vec, 64'h0000_0002_0000_0002);

        // Reset in the middle of ITER aborts without a response.
        send(64'h0000_0064_0000_03E8, 64'h0000_0007_0000_000A, 2'b10, 2'b00, 64'h0000_000E_0000_0064, "aborted");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        name_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_vec", out_vec, 64'd0);
        check("midrst_state_idle", 64'(dbg_state), 64'd0);
        valid_bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid) valid_bad++;
        end
        check("midrst_no_stale_strobe", 64'(valid_bad), 64'd0);

        // SEW=64 with 64-bit lanes disabled: zero result, strobe after edge 2.
        send(64'h0000_0000_0000_00C8, 64'h0101_0101_0101_0107, 2'b00, 2'b00, 64'h0000_0000_0000_001C, "pre_sew64");
        wait_drain("pre_sew64");
        in_vec0  = 64'd100;
        in_vec1  = 64'd7;
        in_sew   = 2'b11;
        in_opSel = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(64'd0);
        name_q.push_back("sew64_disabled");
        @(negedge clk);
        in_valid = 1'b0;
        check("sew64_no_valid_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("sew64_no_valid_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("sew64_valid_edge2", 64'(out_valid), 64'd1);
        check("sew64_out_zero", out_vec, 64'd0);
        wait_drain("sew64");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
